// File: rtl/y86_mem_arbiter.sv
// rtl/y86_mem_arbiter.sv - shares one single-port memory between the y86 core bus and a DMA/loader port
module y86_mem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 8,
    parameter int TIMEOUT  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] cpu_A,
    input  logic          cpu_RE,
    input  logic          cpu_WE,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_done,
    output logic          dma_err,
    output logic          cpu_err,
    output logic [AW-1:0] mem_A,
    output logic          mem_RE,
    output logic          mem_WE,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic [1:0]    owner
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_XFER = 2'd1,
        DMA_XFER = 2'd2
    } state_t;

    state_t        state;
    logic [7:0]    wait_cnt;
    logic [7:0]    to_cnt;
    logic [DW-1:0] cpu_rdata_q;

    logic cpu_req;
    logic dma_win;
    logic cpu_win;
    logic timeout_hit;
    logic xfer_done;

    assign cpu_req     = cpu_RE | cpu_WE;
    assign dma_win     = dma_req & (~cpu_req | (wait_cnt == 8'(MAX_WAIT)));
    assign cpu_win     = ~dma_win & cpu_req;
    assign timeout_hit = (state != IDLE) & ~mem_ack & (to_cnt == 8'(TIMEOUT - 1));
    assign xfer_done   = (state != IDLE) & (mem_ack | timeout_hit);

    // The core samples read data on the edge where stall falls, so the ack cycle passes mem_rdata straight through.
    assign cpu_stall = cpu_req & ~((state == CPU_XFER) & (mem_ack | timeout_hit));
    assign cpu_rdata = (state == CPU_XFER) ? (timeout_hit ? '0 : mem_rdata) : cpu_rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            owner       <= 2'b00;
            wait_cnt    <= '0;
            to_cnt      <= '0;
            mem_A       <= '0;
            mem_wdata   <= '0;
            mem_RE      <= 1'b0;
            mem_WE      <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata   <= '0;
            dma_done    <= 1'b0;
            dma_err     <= 1'b0;
            cpu_err     <= 1'b0;
        end else begin
            dma_done <= 1'b0;
            dma_err  <= 1'b0;
            if (!dma_req) begin
                wait_cnt <= '0;
            end
            case (state)
                IDLE: begin
                    to_cnt <= '0;
                    if (dma_win) begin
                        state     <= DMA_XFER;
                        owner     <= 2'b10;
                        mem_A     <= dma_addr;
                        mem_wdata <= dma_wdata;
                        mem_WE    <= dma_we;
                        mem_RE    <= ~dma_we;
                        wait_cnt  <= '0;
                    end else if (cpu_win) begin
                        // Read and write together resolves to a write.
                        state     <= CPU_XFER;
                        owner     <= 2'b01;
                        mem_A     <= cpu_A;
                        mem_wdata <= cpu_wdata;
                        mem_WE    <= cpu_WE;
                        mem_RE    <= ~cpu_WE;
                        if (dma_req && (wait_cnt != 8'(MAX_WAIT))) begin
                            wait_cnt <= wait_cnt + 8'd1;
                        end
                    end
                end
                CPU_XFER, DMA_XFER: begin
                    if (xfer_done) begin
                        state  <= IDLE;
                        owner  <= 2'b00;
                        mem_RE <= 1'b0;
                        mem_WE <= 1'b0;
                        to_cnt <= '0;
                        if (state == CPU_XFER) begin
                            cpu_rdata_q <= mem_ack ? mem_rdata : '0;
                            if (!mem_ack) begin
                                cpu_err <= 1'b1;
                            end
                        end else if (mem_ack) begin
                            dma_done <= 1'b1;
                            if (!mem_WE) begin
                                dma_rdata <= mem_rdata;
                            end
                        end else begin
                            dma_err <= 1'b1;
                        end
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    owner  <= 2'b00;
                    mem_RE <= 1'b0;
                    mem_WE <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/y86_mem_arbiter.md
Name: y86_mem_arbiter

Overview:
- Shares one single-port memory between the y86 sequential core's bus port and a DMA/loader port.
- Sits between the core's bus_A/bus_RE/bus_WE/bus_out/bus_in and the memory.
- Freezes the core's stage ring through cpu_stall until its access completes.
- Guarantees the DMA port a bounded wait, and aborts any memory access that never acknowledges.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_WAIT, 8, cycles a pending DMA request may lose to the CPU before it gets forced priority (range 1..255).
- TIMEOUT, 16, cycles in a transfer state without mem_ack before the access is aborted (range 2..255).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_A  in  AW  CPU address.
- cpu_RE  in  1  CPU read request; level, held while stalled.
- cpu_WE  in  1  CPU write request; level, held while stalled.
- cpu_wdata  in  DW  CPU write data.
- cpu_rdata  out  DW  read data returned to the CPU.
- cpu_stall  out  1  high: the CPU ring must not advance.
- dma_req  in  1  DMA request; held until dma_done.
- dma_we  in  1  1 = write, 0 = read; stable while dma_req is high.
- dma_addr  in  AW  DMA address.
- dma_wdata  in  DW  DMA write data.
- dma_rdata  out  DW  DMA read data, registered.
- dma_done  out  1  one-cycle completion pulse.
- dma_err  out  1  one-cycle pulse; DMA access timed out.
- cpu_err  out  1  sticky; a CPU access timed out; cleared only by reset.
- mem_A  out  AW  memory address.
- mem_RE  out  1  memory read strobe.
- mem_WE  out  1  memory write strobe.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid when mem_ack is high.
- mem_ack  in  1  memory completion; arbitrary latency of 1 or more cycles.
- owner  out  2  00 = idle, 01 = CPU, 10 = DMA.

Behaviour:
- Reset (rst low) immediately forces:
  - state IDLE, owner 00;
  - mem_RE, mem_WE, dma_done, dma_err and cpu_err at 0;
  - mem_A, mem_wdata, dma_rdata and all latches at 0;
  - wait and timeout counters at 0.
- Reset mid-transfer drops the strobes asynchronously. No completion is reported.
- States:
  - IDLE
    - cpu_req = cpu_RE | cpu_WE.
    - Winner: DMA if dma_req is high and (cpu_req is low, or wait_cnt equals MAX_WAIT); otherwise CPU if cpu_req is high.
    - On the edge, the winner's address, data and direction are latched, and the FSM goes to CPU_XFER or DMA_XFER.
    - If cpu_RE and cpu_WE are both high, it is treated as a write.
  - CPU_XFER / DMA_XFER
    - mem_A, mem_wdata, mem_RE and mem_WE are driven from the latches, so strobes are registered (one cycle after the grant edge).
    - On mem_ack: return to IDLE.
    - On reaching TIMEOUT cycles without mem_ack: abort, pulse dma_err or set cpu_err, and return to IDLE.
- Every transfer occupies at least 2 cycles: one IDLE arbitration cycle plus one or more transfer cycles. Back-to-back grants are therefore separated by one idle cycle with strobes low.
- wait_cnt:
  - increments (saturating at MAX_WAIT) on each IDLE edge where dma_req is high and the CPU wins;
  - clears on a DMA grant, and whenever dma_req is low.
- cpu_stall = cpu_req & ~(state == CPU_XFER & (mem_ack | timeout_hit)). It is combinational. It is high in IDLE while cpu_req is high, and during a DMA transfer.
- cpu_rdata = mem_rdata (combinational pass-through) when state is CPU_XFER; otherwise it holds the last value captured at a CPU ack. The CPU samples on the edge where cpu_stall falls.
- On a timeout abort, cpu_rdata returns 0.
- dma_rdata is captured from mem_rdata on a DMA read ack. dma_done pulses on the cycle after the ack.
- dma_req is low-level sensitive only in IDLE. Dropping it during DMA_XFER does not cancel the transfer, and no dma_done is suppressed.
- mem_ack in IDLE is ignored.
- No combinational path from mem_ack to mem_RE/mem_WE.

Test Plan:
1. CPU read only, mem_ack 1 cycle after strobe, mem_rdata = 0x0000_8B45 → cpu_stall high for 2 cycles, cpu_rdata = 0x0000_8B45 at release, owner 00→01→00.
2. DMA write addr 0x40, data 0xDEADBEEF, ack latency 3 → mem_WE high 3 cycles, mem_A = 0x40, single dma_done pulse the cycle after the ack, CPU idle, cpu_stall low.
3. CPU requests continuously and DMA is pending, MAX_WAIT = 8 → exactly 8 CPU grants, then a DMA grant; wait_cnt returns to 0; CPU stalled during DMA_XFER.
4. cpu_RE and dma_req rise on the same cycle with wait_cnt = 0 → CPU granted first, DMA granted after one idle cycle, no overlap of strobes.
5. DMA read, mem_ack never asserted, TIMEOUT = 16 → strobe dropped after 16 cycles, one dma_err pulse, no dma_done; FSM back in IDLE and serves the next CPU request.
6. rst pulled low in the 2nd cycle of a CPU write → mem_WE falls without waiting for a clock edge, owner 00, cpu_err 0; after release, the held cpu_WE is re-arbitrated and completes normally.
